// File: rtl/pwm_deadtime_ctrl.sv
// pwm_deadtime_ctrl: drives CHANNELS complementary gate legs from raw PWM
// commands, with a programmable deadtime per channel, a global enable, fault
// shutdown and a valid/ready deadtime config port.
//
// Optional build macro: PWM_IN_SYNC_EN. When it is defined, pwm_in passes
// through a 2-flop synchronizer before pwm_q, which adds 2 cycles of latency.
//
// Config handshake: a write is accepted on a rising clk edge where
// cfg_valid & cfg_ready. cfg_valid may be held high. cfg_ready drops for the
// one cycle after every accept. cfg_chan/cfg_dt are sampled only on the accept.
module pwm_deadtime_ctrl #(
  parameter int CHANNELS   = 16,
  parameter int DT_W       = 8,
  parameter int DT_DEFAULT = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fault,
  input  logic [CHANNELS-1:0]   pwm_in,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_chan,
  input  logic [DT_W-1:0]       cfg_dt,
  output logic                  cfg_err,
  output logic [CHANNELS-1:0]   hi_out,
  output logic [CHANNELS-1:0]   lo_out,
  output logic                  fault_latched,
  output logic                  busy,
  output logic [3*CHANNELS-1:0] dbg_state
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_HI    = 3'd1,
    ST_DT_LO = 3'd2,
    ST_LO    = 3'd3,
    ST_DT_HI = 3'd4
  } leg_state_t;

  logic [CHANNELS-1:0] w_pwm_src;
  logic [CHANNELS-1:0] r_pwm_q;

`ifdef PWM_IN_SYNC_EN
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  // Two-flop synchronizer for asynchronous PWM sources
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pwm_src = r_sync2;
`else
  assign w_pwm_src = pwm_in;
`endif

  // Command register: every leg decision is made from pwm_q
  always_ff @(posedge clk) begin
    if (!rst_n) r_pwm_q <= '0;
    else        r_pwm_q <= w_pwm_src;
  end

  logic            r_cfg_ready;
  logic            r_cfg_err;
  logic [DT_W-1:0] r_dt [CHANNELS];
  logic            w_accept;
  logic            w_chan_bad;
  logic [IDX_W-1:0] w_idx;

  assign w_accept   = cfg_valid & r_cfg_ready;
  assign w_chan_bad = ({1'b0, cfg_chan} >= 5'(CHANNELS));
  assign w_idx      = cfg_chan[IDX_W-1:0];

  // Config port: accept, one-cycle ready gap, dt update or error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfg_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) r_dt[ch] <= DT_W'(DT_DEFAULT);
    end else begin
      r_cfg_ready <= !w_accept;
      r_cfg_err   <= w_accept & w_chan_bad;
      if (w_accept && !w_chan_bad) r_dt[w_idx] <= cfg_dt;
    end
  end

  // Fault latch: set by fault, cleared only while disabled with no fault
  always_ff @(posedge clk) begin
    if (!rst_n)       fault_latched <= 1'b0;
    else if (fault)   fault_latched <= 1'b1;
    else if (!enable) fault_latched <= 1'b0;
  end

  leg_state_t      r_state [CHANNELS];
  logic [DT_W-1:0] r_cnt   [CHANNELS];
  leg_state_t      w_nxt   [CHANNELS];
  logic [DT_W-1:0] w_ld    [CHANNELS];
  logic            w_kill;
  logic            w_busy_nxt;

  assign w_kill = fault | !enable;

  // Next-state decode per leg; shutdown overrides every other transition
  always_comb begin
    w_busy_nxt = 1'b0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      w_nxt[ch] = r_state[ch];
      // Counter load value is D-1 with D = max(dt, 1)
      w_ld[ch]  = (r_dt[ch] == '0) ? '0 : r_dt[ch] - DT_W'(1);
      if (w_kill) begin
        w_nxt[ch] = ST_OFF;
      end else begin
        case (r_state[ch])
          ST_OFF:   if (!fault_latched) w_nxt[ch] = r_pwm_q[ch] ? ST_DT_HI : ST_DT_LO;
          ST_HI:    if (!r_pwm_q[ch]) w_nxt[ch] = ST_DT_LO;
          ST_LO:    if (r_pwm_q[ch])  w_nxt[ch] = ST_DT_HI;
          ST_DT_LO: begin
            if (r_pwm_q[ch])               w_nxt[ch] = ST_HI;
            else if (r_cnt[ch] == '0)      w_nxt[ch] = ST_LO;
          end
          ST_DT_HI: begin
            if (!r_pwm_q[ch])              w_nxt[ch] = ST_LO;
            else if (r_cnt[ch] == '0)      w_nxt[ch] = ST_HI;
          end
          default:  w_nxt[ch] = ST_OFF;
        endcase
      end
      if (w_nxt[ch] == ST_DT_LO || w_nxt[ch] == ST_DT_HI) w_busy_nxt = 1'b1;
    end
  end

  // Leg state, deadtime counters and registered output decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_state[ch] <= ST_OFF;
        r_cnt[ch]   <= '0;
      end
      hi_out <= '0;
      lo_out <= '0;
      busy   <= 1'b0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_state[ch] <= w_nxt[ch];
        if ((w_nxt[ch] == ST_DT_LO || w_nxt[ch] == ST_DT_HI) && (w_nxt[ch] != r_state[ch]))
          r_cnt[ch] <= w_ld[ch];
        else if (r_cnt[ch] != '0)
          r_cnt[ch] <= r_cnt[ch] - DT_W'(1);
        hi_out[ch] <= (w_nxt[ch] == ST_HI);
        lo_out[ch] <= (w_nxt[ch] == ST_LO);
      end
      busy <= w_busy_nxt;
    end
  end

  // Debug view of every leg state, 3 bits per leg
  always_comb begin
    dbg_state = '0;
    for (int ch = 0; ch < CHANNELS; ch++) dbg_state[3*ch +: 3] = r_state[ch];
  end

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_pwm_deadtime_ctrl.sv
// Directed bench for pwm_deadtime_ctrl. u_dut is the default 16-leg build;
// u_dut8 is an 8-leg build used for out-of-range config writes.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "after edge k" values reflect the registers updated at k.
module tb_pwm_deadtime_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fault;
  logic [15:0] pwm_in;
  logic        cfg_valid, cfg_ready, cfg_err;
  logic [3:0]  cfg_chan;
  logic [7:0]  cfg_dt;
  logic [15:0] hi_out, lo_out;
  logic        fault_latched, busy;
  logic [47:0] dbg_state;

  logic        cfg8_valid, cfg8_ready, cfg8_err;
  logic [3:0]  cfg8_chan;
  logic [7:0]  cfg8_dt;
  logic [7:0]  hi8, lo8;
  logic        fault_latched8, busy8;
  logic [23:0] dbg_state8;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  // Clock
  always #10 clk = ~clk;

  pwm_deadtime_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault), .pwm_in(pwm_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_dt(cfg_dt),
    .cfg_err(cfg_err), .hi_out(hi_out), .lo_out(lo_out), .fault_latched(fault_latched),
    .busy(busy), .dbg_state(dbg_state)
  );

  pwm_deadtime_ctrl #(.CHANNELS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault), .pwm_in(pwm_in[7:0]),
    .cfg_valid(cfg8_valid), .cfg_ready(cfg8_ready), .cfg_chan(cfg8_chan), .cfg_dt(cfg8_dt),
    .cfg_err(cfg8_err), .hi_out(hi8), .lo_out(lo8), .fault_latched(fault_latched8),
    .busy(busy8), .dbg_state(dbg_state8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one config write on u_dut, waiting a bounded time for ready
  task automatic cfg_write(input logic [3:0] ch, input logic [7:0] dt);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_dt    = dt;
    while (!cfg_ready && n < 8) begin
      step();
      n++;
    end
    check("cfg_ready_before", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("cfg_ready_gap", cfg_ready, 0);
    check("cfg_err_inrange", cfg_err, 0);
    step();
    check("cfg_ready_back", cfg_ready, 1);
  endtask

  // Shoot-through monitor on both builds, every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("no_shoot16", hi_out & lo_out, 0);
      check("no_shoot8", hi8 & lo8, 0);
    end
  end

  initial begin
    int nlow;
    int nlo;
    rst_n = 1'b0; enable = 1'b1; fault = 1'b0; pwm_in = '0;
    cfg_valid = 1'b0; cfg_chan = '0; cfg_dt = '0;
    cfg8_valid = 1'b0; cfg8_chan = '0; cfg8_dt = '0;
    repeat (3) step();

    // Reset state
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    check("rst_busy", busy, 0);
    check("rst_flt", fault_latched, 0);
    check("rst_err", cfg_err, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_ready8", cfg8_ready, 0);

    // Startup: enable=1, pwm_in=0, D=25. DT_LO entered at edge 1 after
    // release, busy for edges 1..25, lo on from edge 26. Meanwhile u_dut8
    // sees cfg_valid held with chan 15: ready 1,0,1,... err pulses per accept.
    rst_n = 1'b1;
    cfg8_valid = 1'b1; cfg8_chan = 4'd15; cfg8_dt = 8'd3;
    exp_q = {2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int c = 1; c <= 26; c++) begin
      step();
      if (c == 6) cfg8_valid = 1'b0;
      if (c <= 7) check("cfg8_ready_err", {cfg8_ready, cfg8_err}, exp_q.pop_front());
      if (c == 1) check("ready_after_rst", cfg_ready, 1);
      check("start_busy", busy, (c <= 25) ? 1 : 0);
      check("start_lo", lo_out, (c >= 26) ? 32'hFFFF : 0);
      check("start_hi", hi_out, 0);
      check("start_lo8", lo8, (c >= 26) ? 32'hFF : 0);
    end
    check("exp_q_empty", exp_q.size(), 0);

    // ch3 dt=5, LO -> HI: lo drops after edge 2, hi rises after edge 7
    cfg_write(4'd3, 8'd5);
    pwm_in[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("ch3_lo", lo_out[3], (k < 2) ? 1 : 0);
      check("ch3_hi", hi_out[3], (k >= 7) ? 1 : 0);
    end

    // ch7 dt=0 behaves as D=1: exactly one both-low cycle per edge
    cfg_write(4'd7, 8'd0);
    pwm_in[7] = 1'b1;
    nlow = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (!hi_out[7] && !lo_out[7]) nlow++;
    end
    check("ch7_rise_gap", nlow, 1);
    check("ch7_rise_hi", hi_out[7], 1);
    pwm_in[7] = 1'b0;
    nlow = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (!hi_out[7] && !lo_out[7]) nlow++;
    end
    check("ch7_fall_gap", nlow, 1);
    check("ch7_fall_lo", lo_out[7], 1);

    // ch0 dt=10: reach HI, then pwm low for 4 cycles -> hi low 4 cycles,
    // low side never turned on, hi back after edge 6
    cfg_write(4'd0, 8'd10);
    pwm_in[0] = 1'b1;
    repeat (12) step();
    check("ch0_hi_on", hi_out[0], 1);
    pwm_in[0] = 1'b0;
    nlow = 0;
    nlo  = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 4) pwm_in[0] = 1'b1;
      if (!hi_out[0]) nlow++;
      if (lo_out[0]) nlo++;
      if (k == 6) check("ch0_hi_back", hi_out[0], 1);
    end
    check("ch0_hi_low_cycles", nlow, 4);
    check("ch0_lo_never", nlo, 0);

    // Fault mid-deadtime on ch0
    pwm_in[0] = 1'b0;
    repeat (3) step();
    check("pre_fault_busy", busy, 1);
    fault = 1'b1;
    step();
    check("flt_hi", hi_out, 0);
    check("flt_lo", lo_out, 0);
    check("flt_busy", busy, 0);
    check("flt_latched", fault_latched, 1);
    enable = 1'b0;
    step();
    check("flt_hold", fault_latched, 1);
    enable = 1'b1;
    fault  = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("latched_off", hi_out | lo_out, 0);
      check("latched_stays", fault_latched, 1);
      check("latched_busy", busy, 0);
    end
    enable = 1'b0;
    step();
    check("latch_clear", fault_latched, 0);

    // Restart with pwm_in = 0x0008: ch3 D=5 to HI, ch7 D=1, ch0 D=10, rest D=25
    enable = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 1) begin
        check("rs_busy", busy, 1);
        check("rs_out", hi_out | lo_out, 0);
      end
      if (k == 2) check("rs_lo_k2", lo_out, 32'h0080);
      if (k == 6) check("rs_hi_k6", hi_out, 32'h0008);
      if (k == 11) check("rs_lo_k11", lo_out, 32'h0081);
      if (k == 26) begin
        check("rs_lo_end", lo_out, 32'hFFF7);
        check("rs_hi_end", hi_out, 32'h0008);
        check("rs_busy_end", busy, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
